// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse train controller.
// Imported by the controller top and its phase timer.
package pulse_pkg;

  localparam int PULSE_W_WIDTH  = 10;
  localparam int PULSE_W_CNT    = 8;
  localparam int PULSE_DEF_HIGH = 219;
  localparam int PULSE_DEF_LOW  = 439;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one high or low phase.
// o_tc flags the last cycle of the loaded phase.
module pulse_phase_timer
  import pulse_pkg::*;
#(
  parameter int W = PULSE_W_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_ctrl.sv
// Burst pulse-train generator with shadowed configuration.
// Outputs are registered from the next-state decode.
module pulse_train_ctrl
  import pulse_pkg::*;
#(
  parameter int W_WIDTH  = PULSE_W_WIDTH,
  parameter int W_CNT    = PULSE_W_CNT,
  parameter int DEF_HIGH = PULSE_DEF_HIGH,
  parameter int DEF_LOW  = PULSE_DEF_LOW
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  input  logic [W_WIDTH-1:0] i_cfg_high,
  input  logic [W_WIDTH-1:0] i_cfg_low,
  input  logic [W_CNT-1:0]   i_cfg_count,
  output logic               o_cfg_ready,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_pulse,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted,
  output logic [W_CNT-1:0]   o_pulse_cnt
);

  state_e             state_q, state_d;
  logic [W_WIDTH-1:0] high_q, high_d;
  logic [W_WIDTH-1:0] low_q, low_d;
  logic [W_CNT-1:0]   count_q, count_d;
  logic [W_CNT-1:0]   pcnt_q, pcnt_d;
  logic [W_CNT-1:0]   pcnt_inc;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic               abrt_q, abrt_d;
  logic               ld, en, tc;
  logic [W_WIDTH-1:0] ld_val;
  logic [W_WIDTH-1:0] hi_in, lo_in;

  // Zero-length phases would stall the timer, so they become one cycle
  assign hi_in = (i_cfg_high == '0) ? W_WIDTH'(1) : i_cfg_high;
  assign lo_in = (i_cfg_low  == '0) ? W_WIDTH'(1) : i_cfg_low;

  assign pcnt_inc    = pcnt_q + W_CNT'(1);
  assign o_cfg_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    abrt_d  = 1'b0;
    ld      = 1'b0;
    en      = 1'b0;
    ld_val  = high_q - W_WIDTH'(1);
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (i_cfg_valid) begin
          high_d  = hi_in;
          low_d   = lo_in;
          count_d = i_cfg_count;
        end
        if (i_start && !i_abort) begin
          state_d = ST_HIGH;
          pcnt_d  = '0;
          ld      = 1'b1;
        end
      end
      (state_q == ST_HIGH): begin
        if (i_abort) begin
          state_d = ST_IDLE;
          abrt_d  = 1'b1;
        end else if (tc) begin
          state_d = ST_LOW;
          ld      = 1'b1;
          ld_val  = low_q - W_WIDTH'(1);
        end else begin
          en = 1'b1;
        end
      end
      (state_q == ST_LOW): begin
        if (i_abort) begin
          state_d = ST_IDLE;
          abrt_d  = 1'b1;
        end else if (tc) begin
          pcnt_d = pcnt_inc;
          if ((count_q != '0) && (pcnt_inc == count_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HIGH;
            ld      = 1'b1;
          end
        end else begin
          en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        abrt_d  = i_abort;
      end
    endcase
    pulse_d = (state_d == ST_HIGH);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      high_q  <= W_WIDTH'(DEF_HIGH);
      low_q   <= W_WIDTH'(DEF_LOW);
      count_q <= '0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  pulse_phase_timer #(
    .W (W_WIDTH)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (ld),
    .i_en       (en),
    .i_load_val (ld_val),
    .o_tc       (tc)
  );

  assign o_pulse     = pulse_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_aborted   = abrt_q;
  assign o_pulse_cnt = pcnt_q;

endmodule
